// File: rtl/sfifo_pkg.sv
// Shared constants and helpers for the sfifo_flags FIFO family.
package sfifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    localparam logic RST_WFULL        = 1'b0;
    localparam logic RST_REMPTY       = 1'b1;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_OVERFLOW     = 1'b0;
    localparam logic RST_UNDERFLOW    = 1'b0;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sfifo_regmem.sv
// Register-array storage: synchronous write port, asynchronous read port.
module sfifo_regmem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; validity is defined solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sfifo_flags.sv
// Single-clock FIFO with arbitrary depth, optional FWFT, occupancy count,
// programmable almost flags and overflow/underflow pulses.
module sfifo_flags
    import sfifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FWFT_OFF,
    localparam int CW      = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wen, ren;
    logic [WIDTH-1:0] mem_rdata;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        wen         = winc & ~wfull;
        ren         = rinc & ~rempty;
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = winc & wfull;
        underflow_d = rinc & rempty;
        if (wen) wp_d = (wp_q == LAST) ? '0 : wp_q + AW'(1);
        if (ren) rp_d = (rp_q == LAST) ? '0 : rp_q + AW'(1);
        case ({wen, ren})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= RST_OVERFLOW;
            underflow_q <= RST_UNDERFLOW;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sfifo_regmem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wen),
        .waddr (wp_q),
        .wdata (wdata),
        .raddr (rp_q),
        .rdata (mem_rdata)
    );

    // Flags decode straight from the count register; no extra pipeline stage.
    assign count        = count_q;
    assign wfull        = (count_q == DEPTH_C);
    assign rempty       = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    generate
        if (FWFT == FWFT_OFF) begin : g_std
            logic [WIDTH-1:0] rdata_q, rdata_d;

            always_comb begin
                rdata_d = ren ? mem_rdata : rdata_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) rdata_q <= '0;
                else     rdata_q <= rdata_d;
            end

            assign rdata = rdata_q;
        end else begin : g_fwft
            assign rdata = mem_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_sfifo_flags.sv
// Scoreboard bench: a queue-based FIFO model feeds expectations to a monitor
// that checks a standard-mode and an FWFT-mode instance every cycle.
module tb_sfifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CW    = 3;

    typedef struct {
        logic [CW-1:0]    cnt;
        logic             full, empty, af, ae, ovf, udf;
        logic [WIDTH-1:0] rd0, front;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             winc, rinc;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] rdata0, rdata1;
    logic             wfull0, rempty0, af0, ae0, ovf0, udf0;
    logic             wfull1, rempty1, af1, ae1, ovf1, udf1;
    logic [CW-1:0]    count0, count1;

    int n_total = 0;
    int n_pass  = 0;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_rd0;

    always #5 clk = ~clk;

    sfifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata0),
        .wfull(wfull0), .rempty(rempty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    sfifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata1),
        .wfull(wfull1), .rempty(rempty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(udf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus and push the model's post-edge expectation.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
        exp_t e;
        int   sz;
        @(negedge clk);
        winc  = w;
        wdata = d;
        rinc  = r;
        sz    = mq.size();
        e.ovf = w && (sz == DEPTH);
        e.udf = r && (sz == 0);
        if (r && sz > 0) m_rd0 = mq.pop_front();
        if (w && sz < DEPTH) mq.push_back(d);
        sz      = mq.size();
        e.cnt   = CW'(sz);
        e.full  = (sz == DEPTH);
        e.empty = (sz == 0);
        e.af    = (sz >= AF);
        e.ae    = (sz <= AE);
        e.rd0   = m_rd0;
        e.front = (sz > 0) ? mq[0] : '0;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_std_rempty"}, 32'(rempty0), 32'd1);
        check({tag, "_std_wfull"},  32'(wfull0),  32'd0);
        check({tag, "_std_count"},  32'(count0),  32'd0);
        check({tag, "_std_ae"},     32'(ae0),     32'd1);
        check({tag, "_std_af"},     32'(af0),     32'd0);
        check({tag, "_std_ovf"},    32'(ovf0),    32'd0);
        check({tag, "_std_udf"},    32'(udf0),    32'd0);
        check({tag, "_std_rdata"},  32'(rdata0),  32'd0);
        check({tag, "_fwft_rempty"}, 32'(rempty1), 32'd1);
        check({tag, "_fwft_count"},  32'(count1),  32'd0);
        check({tag, "_fwft_ae"},     32'(ae1),     32'd1);
    endtask

    // Monitor: compare both instances against the popped expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("std_count",  32'(count0),  32'(e.cnt));
                check("std_wfull",  32'(wfull0),  32'(e.full));
                check("std_rempty", 32'(rempty0), 32'(e.empty));
                check("std_af",     32'(af0),     32'(e.af));
                check("std_ae",     32'(ae0),     32'(e.ae));
                check("std_ovf",    32'(ovf0),    32'(e.ovf));
                check("std_udf",    32'(udf0),    32'(e.udf));
                check("std_rdata",  32'(rdata0),  32'(e.rd0));
                check("fwft_count",  32'(count1),  32'(e.cnt));
                check("fwft_wfull",  32'(wfull1),  32'(e.full));
                check("fwft_rempty", 32'(rempty1), 32'(e.empty));
                check("fwft_af",     32'(af1),     32'(e.af));
                check("fwft_ae",     32'(ae1),     32'(e.ae));
                check("fwft_ovf",    32'(ovf1),    32'(e.ovf));
                check("fwft_udf",    32'(udf1),    32'(e.udf));
                if (!e.empty) check("fwft_rdata", 32'(rdata1), 32'(e.front));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int pw, pr;
        rst   = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;
        m_rd0 = '0;
        #2;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Fill 0x11..0x55, two rejected writes, drain, two rejected reads.
        for (int i = 1; i <= 5; i++) cycle(1'b1, WIDTH'(i * 8'h11), 1'b0);
        cycle(1'b1, 8'hEE, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Pointer wrap-around.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

        // Simultaneous access at count 2, at empty and at full.
        cycle(1'b1, 8'hB0, 1'b0);
        cycle(1'b1, 8'hB1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(8'hC0 + i), 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'hD0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(8'hE0 + i), 1'b0);
        cycle(1'b1, 8'hE9, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // FWFT fall-through: word visible without rinc, then consumed.
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Randomized traffic in phases biased toward full, empty and balanced.
        for (int i = 0; i < 400; i++) begin
            case ((i / 50) % 4)
                0:       begin pw = 80; pr = 25; end
                1:       begin pw = 20; pr = 80; end
                2:       begin pw = 90; pr = 90; end
                default: begin pw = 50; pr = 50; end
            endcase
            cycle($urandom_range(0, 99) < pw, WIDTH'($urandom), $urandom_range(0, 99) < pr);
        end

        // Mid-operation asynchronous reset with data held.
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(8'h70 + i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        mq.delete();
        m_rd0 = '0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
